// File: rtl/ripple_count_capture_pkg.sv
// Shared types and step-flag arithmetic for the ripple counter capture block.
package ripple_count_capture_pkg;

  localparam int MAX_W = 32;

  typedef enum logic {IDLE, PEND} state_t;

  typedef struct packed {
    logic wrap;
    logic skip;
  } flags_t;

  // Step is taken modulo 2^w; a legal single step is +1 (up) or -1 (down).
  function automatic flags_t step_flags(input logic [MAX_W-1:0] nv,
                                        input logic [MAX_W-1:0] ov,
                                        input int               w,
                                        input logic             up);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] delta;
    flags_t           f;
    mask   = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    delta  = (nv - ov) & mask;
    f.wrap = up ? (nv < ov) : (nv > ov);
    f.skip = up ? (delta != MAX_W'(1)) : (delta != mask);
    return f;
  endfunction

endpackage

// File: rtl/ripple_count_capture_bus_sync_ff.sv
// Multi-stage flop chain synchroniser for a bus; each bit is synchronised independently.
module bus_sync_ff #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] ff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff <= '0;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/ripple_count_capture.sv
// Captures settled values of an asynchronous ripple counter and reports each change
// as a valid/ready event tagged with wrap and step-skip flags.
module ripple_count_capture
  import ripple_count_capture_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 2,
  parameter bit UP_MODE     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_count,
  output logic             out_wrap,
  output logic             out_skip,
  output logic             out_ovf
);

  localparam int SW = $clog2(STABLE_CNT + 1);

  logic [WIDTH-1:0] sync_q, prev_q, settled;
  logic [SW-1:0]    stab_cnt, stab_nxt;
  logic             accept, evt, load, set_ovf;
  flags_t           flg;
  state_t           state, state_nxt;

  bus_sync_ff #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (cnt_in),
    .q   (sync_q)
  );

  // Any movement of the synchronised bus restarts the stability window, so
  // incoherent mid-ripple samples never survive long enough to be accepted.
  always_comb begin
    stab_nxt = stab_cnt;
    if (sync_q != prev_q)                    stab_nxt = SW'(1);
    else if (stab_cnt != SW'(STABLE_CNT))    stab_nxt = stab_cnt + SW'(1);
  end

  assign accept = (stab_nxt == SW'(STABLE_CNT));
  assign evt    = accept && (sync_q != settled);
  assign flg    = step_flags(MAX_W'(sync_q), MAX_W'(settled), WIDTH, UP_MODE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q   <= '0;
      stab_cnt <= '0;
      settled  <= '0;
    end else begin
      prev_q   <= sync_q;
      stab_cnt <= stab_nxt;
      if (evt) settled <= sync_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Settled tracking continues while an event is stalled, so a dropped
  // event only costs its report, never the reference for later flags.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    set_ovf   = 1'b0;
    case (state)
      IDLE: if (evt) begin
        load      = 1'b1;
        state_nxt = PEND;
      end
      PEND: begin
        if (out_ready) begin
          if (evt) load = 1'b1;
          else     state_nxt = IDLE;
        end else if (evt) begin
          set_ovf = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_count <= '0;
      out_wrap  <= 1'b0;
      out_skip  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      if (load) begin
        out_count <= sync_q;
        out_wrap  <= flg.wrap;
        out_skip  <= flg.skip;
      end
      if (set_ovf) out_ovf <= 1'b1;
    end
  end

  assign out_valid = (state == PEND);

endmodule

// File: tb/tb_ripple_count_capture.sv
// Directed plus randomized checks of ripple_count_capture in up and down configurations.
module tb_ripple_count_capture;

  logic       clk, rst;
  logic [3:0] cnt;
  logic       rdy_up, rdy_dn;
  logic       up_valid, up_wrap, up_skip, up_ovf;
  logic [3:0] up_count;
  logic       dn_valid, dn_wrap, dn_skip, dn_ovf;
  logic [3:0] dn_count;

  int passed = 0, total = 0;
  int exp_up[$], exp_dn[$], obs_up[$], obs_dn[$];
  int st_up = 0, st_dn = 0;
  int vhi_up = 0;

  ripple_count_capture #(.UP_MODE(1'b1)) dut_up (
    .clk(clk), .rst(rst), .cnt_in(cnt), .out_ready(rdy_up),
    .out_valid(up_valid), .out_count(up_count), .out_wrap(up_wrap),
    .out_skip(up_skip), .out_ovf(up_ovf));

  ripple_count_capture #(.UP_MODE(1'b0)) dut_dn (
    .clk(clk), .rst(rst), .cnt_in(cnt), .out_ready(rdy_dn),
    .out_valid(dn_valid), .out_count(dn_count), .out_wrap(dn_wrap),
    .out_skip(dn_skip), .out_ovf(dn_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor; events encoded as count*4 + wrap*2 + skip.
  always @(negedge clk) begin
    if (up_valid && rdy_up) obs_up.push_back(int'(up_count) * 4 + int'(up_wrap) * 2 + int'(up_skip));
    if (dn_valid && rdy_dn) obs_dn.push_back(int'(dn_count) * 4 + int'(dn_wrap) * 2 + int'(dn_skip));
    if (up_valid) vhi_up++;
  end

  // Reference: modulo-16 step; a normal step is +1 (up) or -1 (down).
  function automatic int model_ev(input int nv, input int ov, input bit up);
    int delta;
    int w, s;
    delta = (nv - ov + 16) % 16;
    w = up ? int'(nv < ov) : int'(nv > ov);
    s = up ? int'(delta != 1) : int'(delta != 15);
    return nv * 4 + w * 2 + s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_step(input int v, input bit drop_up);
    if (v != st_up) begin
      if (!drop_up) exp_up.push_back(model_ev(v, st_up, 1'b1));
      st_up = v;
    end
    if (v != st_dn) begin
      exp_dn.push_back(model_ev(v, st_dn, 1'b0));
      st_dn = v;
    end
  endtask

  task automatic apply(input int v, input int hold, input bit drop_up);
    cnt = 4'(v);
    tick(hold);
    expect_step(v, drop_up);
  endtask

  function automatic int last_up();
    return (obs_up.size() > 0) ? obs_up[$] : -1;
  endfunction

  function automatic int last_dn();
    return (obs_dn.size() > 0) ? obs_dn[$] : -1;
  endfunction

  task automatic drain(input string tag);
    chk({tag, "_nup"}, obs_up.size(), exp_up.size());
    for (int i = 0; i < obs_up.size() && i < exp_up.size(); i++)
      chk($sformatf("%s_up%0d", tag, i), obs_up[i], exp_up[i]);
    chk({tag, "_ndn"}, obs_dn.size(), exp_dn.size());
    for (int i = 0; i < obs_dn.size() && i < exp_dn.size(); i++)
      chk($sformatf("%s_dn%0d", tag, i), obs_dn[i], exp_dn[i]);
    obs_up.delete(); exp_up.delete(); obs_dn.delete(); exp_dn.delete();
  endtask

  initial begin
    int v0, v, g;
    rst = 1'b0; cnt = '0; rdy_up = 1'b1; rdy_dn = 1'b1;
    #12;
    chk("rst_valid", up_valid, 0);
    chk("rst_count", up_count, 0);
    chk("rst_wrap",  up_wrap,  0);
    chk("rst_skip",  up_skip,  0);
    chk("rst_ovf",   up_ovf,   0);
    chk("rst_dn_valid", dn_valid, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick(6);

    // Latency: valid rises after the 4th sampling edge, for one cycle.
    v0 = vhi_up;
    cnt = 4'd1;
    tick(3); chk("lat_e3_valid", up_valid, 0);
    tick(1);
    chk("lat_e4_valid", up_valid, 1);
    chk("lat_e4_count", up_count, 1);
    chk("lat_e4_wrap",  up_wrap,  0);
    chk("lat_e4_skip",  up_skip,  0);
    chk("lat_e4_ovf",   up_ovf,   0);
    tick(1); chk("lat_e5_valid", up_valid, 0);
    tick(3);
    chk("lat_one_cycle", vhi_up - v0, 1);
    expect_step(1, 1'b0);
    drain("t1");

    // Up wrap 15 -> 0.
    apply(15, 8, 1'b0);
    apply(0, 8, 1'b0);
    chk("wrap_up", last_up(), 2);
    drain("t2");

    // One-cycle transient is filtered.
    apply(3, 8, 1'b0);
    cnt = 4'd7; tick(1);
    apply(4, 8, 1'b0);
    chk("glitch", last_up(), 16);
    drain("t3");

    apply(6, 8, 1'b0);
    chk("skip", last_up(), 25);
    drain("t4");

    // Backpressure: second event dropped, settled still tracks it.
    rdy_up = 1'b0;
    apply(1, 8, 1'b0);
    apply(2, 8, 1'b1);
    chk("bp_valid", up_valid, 1);
    chk("bp_count", up_count, 1);
    chk("bp_ovf",   up_ovf,   1);
    rdy_up = 1'b1;
    tick(1);
    chk("bp_release_valid", up_valid, 0);
    apply(3, 8, 1'b0);
    chk("bp_next", last_up(), 12);
    chk("bp_ovf_sticky", up_ovf, 1);
    drain("t5");

    // Asynchronous reset in the middle of a pending event.
    rdy_up = 1'b0;
    apply(9, 8, 1'b1);
    chk("pend_valid", up_valid, 1);
    chk("pend_count", up_count, 9);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", up_valid, 0);
    chk("arst_count", up_count, 0);
    chk("arst_wrap",  up_wrap,  0);
    chk("arst_skip",  up_skip,  0);
    chk("arst_ovf",   up_ovf,   0);
    cnt = 4'd0;
    #2 rst = 1'b1;
    st_up = 0; st_dn = 0; rdy_up = 1'b1;
    v0 = vhi_up;
    tick(10);
    chk("post_rst_quiet", vhi_up - v0, 0);
    drain("t6");

    // Down wrap 0 -> 15.
    apply(15, 8, 1'b0);
    chk("wrap_dn", last_dn(), 62);
    drain("t7");

    // Randomized held values with occasional one-cycle transients.
    for (int i = 0; i < 16; i++) begin
      v = int'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) begin
        g = int'($urandom_range(0, 15));
        cnt = 4'(g);
        tick(1);
      end
      apply(v, int'($urandom_range(6, 10)), 1'b0);
    end
    drain("rnd");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
